// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU widths, operation encodings and port identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN_DEF = 32;

  // funct3-style operation encodings
  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  // funct7-style extension selecting SUB/SRA
  localparam logic [6:0] ALU_EXT_ALT  = 7'b0100000;
  localparam logic [6:0] ALU_EXT_NONE = 7'b0000000;

  typedef enum logic {
    PORT_MAIN   = 1'b0,
    PORT_HELPER = 1'b1
  } port_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with one-hot grant and pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  port_e r_ptr;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = (r_ptr == PORT_HELPER) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // After a grant the other port becomes favoured; idle/stall cycles hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PORT_MAIN;
    end else if (advance && (grant != 2'b00)) begin
      r_ptr <= grant[0] ? PORT_HELPER : PORT_MAIN;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Shares one combinational ALU between two requesters and
//               returns results through a single-entry response register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_op1,
  input  logic [XLEN-1:0]  req0_op2,
  input  logic [2:0]       req0_alu_op,
  input  logic [6:0]       req0_alu_op_ext,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_op1,
  input  logic [XLEN-1:0]  req1_op2,
  input  logic [2:0]       req1_alu_op,
  input  logic [6:0]       req1_alu_op_ext,
  input  logic [TAG_W-1:0] req1_tag,

  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [2:0]       alu_op,
  output logic [6:0]       alu_op_ext,
  input  logic [XLEN-1:0]  alu_res,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [XLEN-1:0]  rsp_res
);

  logic             r_rsp_valid;
  logic             r_rsp_src;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [XLEN-1:0]  r_rsp_res;

  logic             w_slot_free;
  logic             w_enable;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic [TAG_W-1:0] w_tag;

  // Draining and refilling in the same cycle keeps one op per cycle.
  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_enable    = w_slot_free && !rst;
  assign w_accept    = |w_grant;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .enable  (w_enable),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_op     = '0;
    alu_op_ext = '0;
    w_tag      = '0;
    if (w_grant[0]) begin
      alu_op1    = req0_op1;
      alu_op2    = req0_op2;
      alu_op     = req0_alu_op;
      alu_op_ext = req0_alu_op_ext;
      w_tag      = req0_tag;
    end else if (w_grant[1]) begin
      alu_op1    = req1_op1;
      alu_op2    = req1_op2;
      alu_op     = req1_alu_op;
      alu_op_ext = req1_alu_op_ext;
      w_tag      = req1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_res   <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_src   <= w_grant[1];
      r_rsp_tag   <= w_tag;
      r_rsp_res   <= alu_res;
    end else if (rsp_ready) begin
      // Data fields keep their last values after a plain drain.
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_src   = r_rsp_src;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_res   = r_rsp_res;

endmodule : alu_rr_arbiter

`default_nettype wire
